// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle CPU control path.
//   CtrlState              : controller state encoding (FETCH..HALT)
//   MemAddrSel             : memory address source (PC for fetch, ALU result for data)
//   PcSel                  : next-PC source (PC+4 or branch target)
//   DEFAULT_COUNTER_WIDTH  : default width of the optional performance counters
// Optional feature macro referenced by users of this package: MULTICYCLE_PERF_COUNTER_EN
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } CtrlState;

    typedef enum logic {
        ADDR_PC  = 1'b0,
        ADDR_ALU = 1'b1
    } MemAddrSel;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_BRANCH = 1'b1
    } PcSel;

    localparam int DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port request/ready handshake.
//   memReq      : request valid (master -> slave)
//   memWrEnable : request is a write (master -> slave)
//   memAddrSel  : address source select (master -> slave)
//   memReady    : slave accepts/completes the request this cycle (slave -> master)
// A transfer happens in a cycle where memReq && memReady.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic      memReq;
    logic      memWrEnable;
    MemAddrSel memAddrSel;
    logic      memReady;

    modport master (
        output memReq,
        output memWrEnable,
        output memAddrSel,
        input  memReady
    );

    modport slave (
        input  memReq,
        input  memWrEnable,
        input  memAddrSel,
        output memReady
    );

endinterface

// File: rtl/multicycle_controller_perf_counter.sv
// Generic free-running incrementer with synchronous clear and count enable.
// Wraps modulo 2^WIDTH.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   en    : increment enable
//   count : current count value
module multicycle_controller_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM. Sequences fetch/decode/execute/memory/writeback
// over one shared memory port and emits one retire pulse per instruction.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem (master)                  : shared memory port handshake
//   isLoad/isStore/isBranch       : decoded instruction class
//   regWrEnable, isIllegal        : decoded rd write / unsupported opcode
//   brTaken                       : branch condition result
//   irWrEnable, pcWrEnable, pcSel : IR latch, PC update and next-PC select
//   rfWrEnable, wbSel             : register write and writeback source
//   retire, halted                : instruction-complete pulse, stopped flag
//   cycleCount, retireCount       : performance counters
// Build option: MULTICYCLE_PERF_COUNTER_EN builds the counters; without it
// both counter outputs are constant zero.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_controller_if.master  mem,
    input  logic                     isLoad,
    input  logic                     isStore,
    input  logic                     isBranch,
    input  logic                     regWrEnable,
    input  logic                     isIllegal,
    input  logic                     brTaken,
    output logic                     irWrEnable,
    output logic                     pcWrEnable,
    output PcSel                     pcSel,
    output logic                     rfWrEnable,
    output logic                     wbSel,
    output logic                     retire,
    output logic                     halted,
    output logic [COUNTER_WIDTH-1:0] cycleCount,
    output logic [COUNTER_WIDTH-1:0] retireCount
);

    CtrlState state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            unique case (state_reg)
                FETCH:   if (mem.memReady) state_reg <= DECODE;
                DECODE:  state_reg <= isIllegal ? HALT : EXEC;
                EXEC: begin
                    if (isBranch)               state_reg <= FETCH;
                    else if (isLoad || isStore) state_reg <= MEM;
                    else                        state_reg <= WB;
                end
                // A data access that is not a store is treated as a load.
                MEM:     if (mem.memReady) state_reg <= isStore ? FETCH : WB;
                WB:      state_reg <= FETCH;
                HALT:    state_reg <= HALT;
                default: state_reg <= FETCH;
            endcase
        end
    end

    // Outputs are decoded combinationally so the request drops in the very
    // cycle reset is seen, and irWrEnable can follow memReady within FETCH.
    always_comb begin
        mem.memReq      = 1'b0;
        mem.memWrEnable = 1'b0;
        mem.memAddrSel  = ADDR_PC;
        irWrEnable      = 1'b0;
        pcWrEnable      = 1'b0;
        pcSel           = PC_PLUS4;
        rfWrEnable      = 1'b0;
        wbSel           = 1'b0;
        retire          = 1'b0;
        halted          = 1'b0;
        if (!rst) begin
            unique case (state_reg)
                FETCH: begin
                    mem.memReq = 1'b1;
                    irWrEnable = mem.memReady;
                end
                EXEC: begin
                    if (isBranch) begin
                        pcWrEnable = 1'b1;
                        pcSel      = brTaken ? PC_BRANCH : PC_PLUS4;
                        retire     = 1'b1;
                    end
                end
                MEM: begin
                    mem.memReq      = 1'b1;
                    mem.memAddrSel  = ADDR_ALU;
                    mem.memWrEnable = isStore;
                    if (mem.memReady && isStore) begin
                        pcWrEnable = 1'b1;
                        retire     = 1'b1;
                    end
                end
                WB: begin
                    rfWrEnable = regWrEnable;
                    wbSel      = isLoad;
                    pcWrEnable = 1'b1;
                    retire     = 1'b1;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_COUNTER_EN
    generate
        if (1) begin : gen_perf
            multicycle_controller_perf_counter #(
                .WIDTH (COUNTER_WIDTH)
            ) u_cycle_count (
                .clk   (clk),
                .clr   (rst),
                .en    (1'b1),
                .count (cycleCount)
            );

            multicycle_controller_perf_counter #(
                .WIDTH (COUNTER_WIDTH)
            ) u_retire_count (
                .clk   (clk),
                .clr   (rst),
                .en    (retire),
                .count (retireCount)
            );
        end
    endgenerate
`else
    assign cycleCount  = '0;
    assign retireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Each scenario task drives
// per-cycle stimulus and compares the full output vector against hand-derived
// expectations. Output vector bit order:
//   [9] memReq [8] memWrEnable [7] memAddrSel [6] irWrEnable [5] pcWrEnable
//   [4] pcSel  [3] rfWrEnable  [2] wbSel      [1] retire     [0] halted
module tb_multicycle_controller;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          isLoad, isStore, isBranch, regWrEnable, isIllegal, brTaken;
    logic          irWrEnable, pcWrEnable, rfWrEnable, wbSel, retire, halted;
    logic          pcSel;
    logic [CW-1:0] cycleCount, retireCount;

    int pass_count  = 0;
    int check_count = 0;

    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_FETCH = 10'b1001000000; // FETCH with memReady=1
    localparam logic [9:0] V_FWAIT = 10'b1000000000; // FETCH with memReady=0
    localparam logic [9:0] V_HALT  = 10'b0000000001;

    multicycle_controller_if mem_if ();

    multicycle_controller #(
        .COUNTER_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_if),
        .isLoad      (isLoad),
        .isStore     (isStore),
        .isBranch    (isBranch),
        .regWrEnable (regWrEnable),
        .isIllegal   (isIllegal),
        .brTaken     (brTaken),
        .irWrEnable  (irWrEnable),
        .pcWrEnable  (pcWrEnable),
        .pcSel       (pcSel),
        .rfWrEnable  (rfWrEnable),
        .wbSel       (wbSel),
        .retire      (retire),
        .halted      (halted),
        .cycleCount  (cycleCount),
        .retireCount (retireCount)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {mem_if.memReq, mem_if.memWrEnable, logic'(mem_if.memAddrSel),
                  irWrEnable, pcWrEnable, pcSel, rfWrEnable, wbSel, retire, halted};

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_class(input logic ld, input logic st, input logic br,
                             input logic rw, input logic il, input logic bt);
        isLoad = ld; isStore = st; isBranch = br;
        regWrEnable = rw; isIllegal = il; brTaken = bt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_if.memReady = 1'b0;
        set_class(0, 0, 0, 0, 0, 0);
        tick(); tick();
        #1;
        check_count++;
        if (obs !== V_IDLE) $display("FAIL reset_idle obs=%b exp=%b", obs, V_IDLE);
        else pass_count++;
        // Outputs must stay forced low during reset whatever the inputs do.
        mem_if.memReady = 1'b1;
        set_class(1, 1, 1, 1, 1, 1);
        #1;
        check_count++;
        if (obs !== V_IDLE) $display("FAIL reset_forced obs=%b exp=%b", obs, V_IDLE);
        else pass_count++;
        tick();
        set_class(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL reset_first_fetch obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    task automatic test_counters_tied();
`ifndef MULTICYCLE_PERF_COUNTER_EN
        check_count++;
        if (cycleCount !== '0) $display("FAIL cycle_count_tied got=%0d exp=0", cycleCount);
        else pass_count++;
        check_count++;
        if (retireCount !== '0) $display("FAIL retire_count_tied got=%0d exp=0", retireCount);
        else pass_count++;
`endif
    endtask

    task automatic test_alu();
        logic [9:0] exp_v [4];
        exp_v = '{V_FETCH, V_IDLE, V_IDLE, 10'b0000101010};
        set_class(0, 0, 0, 1, 0, 0);
        mem_if.memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL alu cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            tick();
        end
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL alu_next_fetch obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    task automatic test_load_wait();
        logic [9:0] exp_v [7];
        logic       rdy_v [7];
        exp_v = '{V_FETCH, V_IDLE, V_IDLE, 10'b1010000000, 10'b1010000000,
                  10'b1010000000, 10'b0000101110};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        set_class(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            mem_if.memReady = rdy_v[i];
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL load_wait cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            tick();
        end
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL load_next_fetch obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    // Store preceded by one fetch wait cycle; regWrEnable held high to show
    // that a store never writes the register file.
    task automatic test_store();
        logic [9:0] exp_v [5];
        logic       rdy_v [5];
        exp_v = '{V_FWAIT, V_FETCH, V_IDLE, V_IDLE, 10'b1110100010};
        rdy_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        set_class(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            mem_if.memReady = rdy_v[i];
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL store cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            tick();
        end
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL store_next_fetch obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    task automatic test_back_to_back_branch();
        logic [9:0] exp_v [6];
        logic       bt_v  [6];
        exp_v = '{V_FETCH, V_IDLE, 10'b0000110010, V_FETCH, V_IDLE, 10'b0000100010};
        bt_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        mem_if.memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_class(0, 0, 1, 0, 0, bt_v[i]);
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL branch cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            tick();
        end
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL branch_next_fetch obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    task automatic test_reset_mid_mem();
        logic [9:0] exp_v [4];
        logic       rdy_v [4];
        exp_v = '{V_FETCH, V_IDLE, V_IDLE, 10'b1010000000};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        set_class(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            mem_if.memReady = rdy_v[i];
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL mid_mem cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            if (i < 3) tick();
        end
        rst = 1'b1;
        mem_if.memReady = 1'b1;
        #1;
        check_count++;
        if (obs !== V_IDLE) $display("FAIL mid_mem_rst_drop obs=%b exp=%b", obs, V_IDLE);
        else pass_count++;
        tick();
        rst = 1'b0;
        set_class(0, 0, 0, 0, 0, 0);
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL mid_mem_restart obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

    task automatic test_illegal();
        logic [9:0] exp_v [7];
        exp_v = '{V_FETCH, V_IDLE, V_HALT, V_HALT, V_HALT, V_HALT, V_HALT};
        mem_if.memReady = 1'b1;
        set_class(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) begin
            // Toggle class inputs in HALT to show they are ignored there.
            if (i >= 3) set_class(i[0], ~i[0], 1, 1, 0, 1);
            #1;
            check_count++;
            if (obs !== exp_v[i]) $display("FAIL illegal cycle%0d obs=%b exp=%b", i + 1, obs, exp_v[i]);
            else pass_count++;
            tick();
        end
        rst = 1'b1;
        #1;
        check_count++;
        if (obs !== V_IDLE) $display("FAIL halt_rst obs=%b exp=%b", obs, V_IDLE);
        else pass_count++;
        tick();
        rst = 1'b0;
        set_class(0, 0, 0, 0, 0, 0);
        #1;
        check_count++;
        if (obs !== V_FETCH) $display("FAIL halt_restart obs=%b exp=%b", obs, V_FETCH);
        else pass_count++;
    endtask

`ifdef MULTICYCLE_PERF_COUNTER_EN
    task automatic test_perf_counters();
        rst = 1'b1;
        mem_if.memReady = 1'b1;
        set_class(0, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        check_count++;
        if (cycleCount !== 32'd0) $display("FAIL perf_cycle_reset got=%0d exp=0", cycleCount);
        else pass_count++;
        repeat (40) tick();
        #1;
        check_count++;
        if (retireCount !== 32'd10) $display("FAIL perf_retire_10 got=%0d exp=10", retireCount);
        else pass_count++;
        check_count++;
        if (cycleCount !== 32'd40) $display("FAIL perf_cycle_40 got=%0d exp=40", cycleCount);
        else pass_count++;
        force dut.gen_perf.u_retire_count.count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.gen_perf.u_retire_count.count_reg;
        repeat (4) tick();
        #1;
        check_count++;
        if (retireCount !== 32'd0) $display("FAIL perf_retire_wrap got=%0d exp=0", retireCount);
        else pass_count++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_back_to_back_branch();
        test_reset_mid_mem();
        test_counters_tied();
`ifdef MULTICYCLE_PERF_COUNTER_EN
        test_perf_counters();
`endif
        test_illegal();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the CPU datapath over several cycles. It lets the CPU use one shared instruction/data memory port with a request/ready handshake instead of separate single-cycle memories. It sits beside the Decoder and drives the enables and select lines of the PC, instruction register, register file, ALU input mux and memory port. It consumes decoded instruction class bits and the branch-taken flag, and produces a one-cycle retire pulse per instruction.

## Interface
- COUNTER_WIDTH, 32, width of performance counters (only with the perf-counter macro)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- isLoad  in  1  decoded instruction is a load
- isStore  in  1  decoded instruction is a store
- isBranch  in  1  decoded instruction is a conditional branch
- regWrEnable  in  1  decoded instruction writes rd
- isIllegal  in  1  decoded opcode is unsupported
- brTaken  in  1  branch unit condition result
- memReady  in  1  memory port accepts/completes the current request this cycle
- memReq  out  1  memory request valid
- memWrEnable  out  1  memory request is a write
- memAddrSel  out  1  0 = PC (fetch), 1 = ALU result (data)
- irWrEnable  out  1  latch instruction register
- pcWrEnable  out  1  update PC
- pcSel  out  1  0 = PC+4, 1 = branch target
- rfWrEnable  out  1  register file write
- wbSel  out  1  0 = ALU result, 1 = memory data
- retire  out  1  one-cycle pulse, instruction completed
- halted  out  1  FSM stopped on illegal instruction
- cycleCount  out  COUNTER_WIDTH  cycles since reset (macro only)
- retireCount  out  COUNTER_WIDTH  retired instructions (macro only)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. The state is registered; all outputs decode combinationally from the state and inputs.
- FETCH: memReq=1, memAddrSel=0, memWrEnable=0. irWrEnable = memReady. Move to DECODE on memReady, otherwise stay.
- DECODE:
  - isIllegal → HALT.
  - Otherwise → EXEC.
- EXEC:
  - Branch: pcWrEnable=1, pcSel=brTaken, retire=1 → FETCH.
  - Load or store → MEM.
  - Otherwise → WB.
- MEM: memReq=1, memAddrSel=1, memWrEnable=isStore. Stay until memReady.
  - Store, on memReady: pcWrEnable=1, pcSel=0, retire=1 → FETCH.
  - Load, on memReady → WB.
- WB: rfWrEnable=regWrEnable, wbSel=isLoad, pcWrEnable=1, pcSel=0, retire=1 → FETCH.
- HALT: halted=1, all other outputs 0. Sticky until rst.
- Instruction class inputs are sampled only in DECODE/EXEC/MEM/WB. They are required to be stable from DECODE until retire, because the IR holds them.
- Exactly one of pcWrEnable-with-retire occurs per instruction. retire and pcWrEnable always coincide.

## Timing
- While rst=1: state ← FETCH. All outputs are forced to 0, including memReq.
- First cycle after rst falls: FETCH with memReq=1.
- Handshake:
  - A transfer occurs in the cycle where memReq && memReady.
  - memReq, memAddrSel and memWrEnable stay constant until that cycle.
  - memReady while memReq=0 is ignored.
- Cycles per instruction with a zero-wait memory (memReady tied 1):
  - branch 3
  - ALU/jump-free 4
  - store 4
  - load 5
- Each wait cycle adds exactly 1 cycle to FETCH or MEM.
- rst asserted mid-MEM: the request drops in the same cycle rst is seen. No retire, no rfWrEnable.
- isIllegal set in DECODE: HALT is entered next cycle with no retire and no PC write.

## Configuration
- MULTICYCLE_PERF_COUNTER_EN defined:
  - cycleCount increments every non-reset cycle, including HALT.
  - retireCount increments on retire.
  - Both reset to 0 and wrap modulo 2^COUNTER_WIDTH.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- The shared Types package gains:
  - the state enum CtrlState (FETCH..HALT)
  - MemAddrSel and PcSel typedefs with their named constants
  - the COUNTER_WIDTH default constant
- One sub-module, perf_counter: a generic COUNTER_WIDTH incrementer with synchronous clear and enable. It is instantiated twice under the macro.

## Test plan
- ALU instruction (regWrEnable=1), memReady=1 → states FETCH, DECODE, EXEC, WB. rfWrEnable=1 and retire=1 in cycle 4, and next cycle is FETCH.
- Load with memReady low for 2 MEM cycles → memReq=1, memAddrSel=1 held for 3 cycles. WB has wbSel=1 and rfWrEnable=1. Total 7 cycles.
- Store, zero-wait → memWrEnable=1 in MEM, with retire, pcWrEnable=1 and pcSel=0 in the same cycle. rfWrEnable never 1.
- Branch with brTaken=1 then 0 → retire in cycle 3 with pcSel=1, then pcSel=0. No MEM/WB visits.
- isIllegal=1 → halted=1 from cycle 3 onward, memReq=0 forever. rst for 1 cycle restarts FETCH.
- Macro defined: 10 ALU instructions, zero-wait → retireCount=10, cycleCount=40. Force retireCount to 2^32−1 then retire one instruction → retireCount=0.
